zigzag_seq_ctrl: RTL and testbench
==================================

Name: zigzag_seq_ctrl

Overview:
- Sequences the 64x8-bit zigzag block buffer for one 8x8 block at a time.
- Accepts eight 64-bit quantized rows from upstream over a valid/ready handshake and issues row writes into the buffer. The buffer's write path has a 2-cycle delay, so row data is re-timed to match it.
- Once all eight writes have landed, fires the zigzag enable window and presents the 512-bit zigzag result to the downstream entropy coder with valid/ready.
- Sits between the quantizer output and the Huffman/RLE stage.

Parameters:
- ROWS, 8, rows per block (row counter wraps at ROWS-1).
- WR_DELAY, 2, cycles from buf_input_data_enable to the buffer write; row data is delayed by the same amount.
- ZZ_LAT, 3, cycles buf_zigzag_enable is held high before zigzag_pix_out holds the new block.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller can accept a row.
- in_row_data  in  64  row of 8 pixels, pixel 0 in bits [7:0].
- buf_input_enable  out  1  bulk-load enable; constant 0.
- buf_input_data_enable  out  1  one-cycle row-write pulse.
- buf_matrix_row  out  8  row index for the write, 0..7.
- buf_row_data  out  64  row data, delayed WR_DELAY cycles after its pulse.
- buf_zigzag_enable  out  1  zigzag reorder/capture enable.
- zz_out_valid  out  1  zigzag_pix_out holds a complete block.
- zz_out_ready  in  1  downstream accepts the block.
- busy  out  1  a block is in progress.
- block_count  out  16  count of blocks delivered (wraps).

Behaviour:
- Reset (async, active-high): all outputs 0, state LOAD, row_cnt 0, delay line cleared.
- FSM states: LOAD, DRAIN, ZZ, OUT.

LOAD:
- in_ready=1.
- Each accept (in_valid & in_ready) in cycle t produces, in cycle t+1:
  - buf_input_data_enable=1;
  - buf_matrix_row=row_cnt (pre-increment);
  - buf_row_data=in_row_data from cycle t, in cycle t+1+WR_DELAY.
- buf_row_data holds its last value otherwise.
- row_cnt increments per accept.
- Accepting row ROWS-1 moves to DRAIN with row_cnt=0, and in_ready drops the next cycle.
- Gaps between beats are allowed; no timeout.

DRAIN:
- in_ready=0.
- Waits WR_DELAY+1 cycles after the last write pulse, so all writes have completed before zigzag starts.
- Then moves to ZZ.

ZZ:
- buf_zigzag_enable=1 for exactly ZZ_LAT consecutive cycles, then 0.
- Then moves to OUT.

OUT:
- zz_out_valid=1 (registered), starting the cycle after the last enable cycle.
- Held until zz_out_ready=1 in the same cycle.
- On handshake:
  - zz_out_valid drops next cycle;
  - block_count += 1;
  - state returns to LOAD.
- in_ready=0 throughout OUT, so the buffer and zigzag_pix_out are not overwritten before acceptance.

Other rules:
- zz_out_ready while not in OUT is ignored.
- busy = (state != LOAD) | (row_cnt != 0).
- block_count wraps 0xFFFF -> 0x0000.
- Reset mid-block: the block is abandoned and pending buffer writes are squashed (the delay line is cleared). The next accepted row is row 0.
- in_valid while in_ready=0 is held upstream; nothing is dropped or duplicated.

Test Plan:
- Reset, then 8 back-to-back rows 0x0706050403020100 + 0x0808080808080808*r:
  - write pulses in 8 consecutive cycles, rows 0..7;
  - each buf_row_data matches its pulse's row, 2 cycles later;
  - buf_zigzag_enable high 3 cycles;
  - zz_out_valid rises and the zigzag output equals the golden zigzag of ramp 0..63.
- Rows delivered with in_valid gaps of 0-5 random cycles -> identical output; buf_matrix_row still 0..7 in order.
- zz_out_ready held low 20 cycles in OUT:
  - zz_out_valid stays 1 and in_ready stays 0;
  - a new row offered during the stall is not accepted;
  - after ready, block_count=1 and the offered row is written as row 0.
- Reset asserted after row 4 of a block -> all outputs 0 at once and no further write pulses; a fresh 8-row block then completes with a correct result.
- 3 consecutive blocks with zz_out_ready tied 1 -> three zz_out_valid pulses, block_count=3, busy=0 afterwards.
- block_count preloaded by forcing to 0xFFFF, then one block -> block_count=0x0000.

Source files
------------

// File: rtl/zigzag_seq_ctrl.sv
// zigzag_seq_ctrl: sequences the 64x8-bit zigzag block buffer for one 8x8 block at a time.
// Rows from the quantizer are accepted over valid/ready and issued as row-write pulses to the
// buffer. Row data is re-timed to the buffer's write delay. After the last write has landed,
// the zigzag enable window is fired and the block is offered downstream over valid/ready.
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   in_valid/in_ready      upstream row handshake, in_row_data = 8 pixels (pixel 0 in [7:0])
//   buf_input_enable       bulk-load enable, tied 0
//   buf_input_data_enable  one-cycle row-write pulse
//   buf_matrix_row         row index for the write
//   buf_row_data           row data, valid WR_DELAY cycles after its pulse
//   buf_zigzag_enable      zigzag reorder/capture window
//   zz_out_valid/ready     downstream block handshake
//   busy                   a block is in progress
//   block_count            blocks delivered, wrapping
module zigzag_seq_ctrl #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned WR_DELAY = 2,
    parameter int unsigned ZZ_LAT   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_row_data,
    output logic        buf_input_enable,
    output logic        buf_input_data_enable,
    output logic [7:0]  buf_matrix_row,
    output logic [63:0] buf_row_data,
    output logic        buf_zigzag_enable,
    output logic        zz_out_valid,
    input  logic        zz_out_ready,
    output logic        busy,
    output logic [15:0] block_count
);

    typedef enum logic [1:0] {StLoad, StDrain, StZz, StOut} state_e;

    state_e      state_q, state_d;
    logic [7:0]  row_cnt_q, row_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] block_count_q, block_count_d;
    logic        in_ready_q, in_ready_d;
    logic        zz_valid_q, zz_valid_d;
    logic        wr_pulse_q;
    logic [7:0]  wr_row_q;
    logic        accept;

    // Delay line that re-times row data to the buffer's write path.
    logic [63:0]         pipe_data_q [WR_DELAY];
    logic [WR_DELAY-1:0] pipe_vld_q;
    logic [63:0]         buf_row_data_q;

    // in_ready is only ever high in LOAD, so this is the LOAD-state accept.
    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        cnt_d         = cnt_q;
        block_count_d = block_count_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (row_cnt_q == 8'(ROWS - 1)) begin
                        row_cnt_d = 8'd0;
                        cnt_d     = 8'd0;
                        state_d   = StDrain;
                    end else begin
                        row_cnt_d = row_cnt_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                // Entered alongside the last write pulse; WR_DELAY+1 cycles here lets it land.
                if (cnt_q == 8'(WR_DELAY)) begin
                    cnt_d   = 8'd0;
                    state_d = StZz;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StZz: begin
                if (cnt_q == 8'(ZZ_LAT - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StOut: begin
                if (zz_out_ready) begin
                    block_count_d = block_count_q + 16'd1;
                    state_d       = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
        in_ready_d = (state_d == StLoad);
        zz_valid_d = (state_d == StOut);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StLoad;
            row_cnt_q     <= 8'd0;
            cnt_q         <= 8'd0;
            block_count_q <= 16'd0;
            in_ready_q    <= 1'b0;
            zz_valid_q    <= 1'b0;
            wr_pulse_q    <= 1'b0;
            wr_row_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            cnt_q         <= cnt_d;
            block_count_q <= block_count_d;
            in_ready_q    <= in_ready_d;
            zz_valid_q    <= zz_valid_d;
            wr_pulse_q    <= accept;
            if (accept) begin
                wr_row_q <= row_cnt_q;
            end
        end
    end

    // Reset clears the delay line so writes from an abandoned block never reach the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(WR_DELAY); k++) begin
                pipe_data_q[k] <= '0;
            end
            pipe_vld_q     <= '0;
            buf_row_data_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            if (accept) begin
                pipe_data_q[0] <= in_row_data;
            end
            for (int k = 1; k < int'(WR_DELAY); k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_data_q[k] <= pipe_data_q[k-1];
            end
            if (pipe_vld_q[WR_DELAY-1]) begin
                buf_row_data_q <= pipe_data_q[WR_DELAY-1];
            end
        end
    end

    assign in_ready              = in_ready_q;
    assign buf_input_enable      = 1'b0;
    assign buf_input_data_enable = wr_pulse_q;
    assign buf_matrix_row        = wr_row_q;
    assign buf_row_data          = buf_row_data_q;
    assign buf_zigzag_enable     = (state_q == StZz);
    assign zz_out_valid          = zz_valid_q;
    assign busy                  = (state_q != StLoad) | (row_cnt_q != 8'd0);
    assign block_count           = block_count_q;

endmodule

// File: tb/tb_zigzag_seq_ctrl.sv
// Scoreboard bench for zigzag_seq_ctrl. The stimulus process pushes expected row writes and
// expected blocks; a monitor process models the block buffer and checks outputs as they appear.
module tb_zigzag_seq_ctrl;

    localparam int WrDelay = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_row_data;
    logic        buf_input_enable;
    logic        buf_input_data_enable;
    logic [7:0]  buf_matrix_row;
    logic [63:0] buf_row_data;
    logic        buf_zigzag_enable;
    logic        zz_out_valid;
    logic        zz_out_ready;
    logic        busy;
    logic [15:0] block_count;

    zigzag_seq_ctrl dut (
        .clock                 (clock),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_row_data           (in_row_data),
        .buf_input_enable      (buf_input_enable),
        .buf_input_data_enable (buf_input_data_enable),
        .buf_matrix_row        (buf_matrix_row),
        .buf_row_data          (buf_row_data),
        .buf_zigzag_enable     (buf_zigzag_enable),
        .zz_out_valid          (zz_out_valid),
        .zz_out_ready          (zz_out_ready),
        .busy                  (busy),
        .block_count           (block_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  row;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        int          due;
        logic [7:0]  row;
        logic [63:0] data;
    } pend_t;

    typedef struct {
        logic [511:0] zz;
        logic [15:0]  cnt;
    } blk_t;

    wr_t   wr_exp[$];
    pend_t pend[$];
    blk_t  blk_q[$];

    int checks = 0;
    int errors = 0;
    int zr[64];
    int zc[64];
    logic [63:0]  mem[8];
    logic [511:0] zz_model;
    logic [15:0]  exp_blocks;
    int cyc = 0;
    int en_cnt = 0;
    int hs_cnt = 0;
    int p0 = 0;
    int p7 = 0;
    bit cnt_chk = 0;
    logic [15:0] cnt_exp;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] row_data(input int b, input int r);
        logic [63:0] d;
        for (int c = 0; c < 8; c++) d[8*c +: 8] = 8'(8 * r + c + 64 * b);
        return d;
    endfunction

    // Zigzag of a block whose pixel (r,c) is 8r+c+64b.
    function automatic logic [511:0] golden(input int b);
        logic [511:0] g;
        for (int k = 0; k < 64; k++) g[8*k +: 8] = 8'(8 * zr[k] + zc[k] + 64 * b);
        return g;
    endfunction

    // Monitor: samples just after the falling edge, where inputs already hold the values the DUT
    // will see at the next rising edge.
    initial begin : monitor
        wr_t   e;
        pend_t p;
        blk_t  bk;
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (reset) begin
                pend.delete();
                en_cnt  = 0;
                cnt_chk = 0;
            end else begin
                if (cnt_chk) begin
                    check("block_count", 512'(block_count), 512'(cnt_exp));
                    check("valid_drop", 512'(zz_out_valid), 512'(0));
                    cnt_chk = 0;
                end
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    p = pend.pop_front();
                    check("row_data", 512'(buf_row_data), 512'(p.data));
                    mem[p.row[2:0]] = buf_row_data;
                end
                if (buf_input_data_enable) begin
                    if (wr_exp.size() == 0) begin
                        check("unexpected_write", 512'(1), 512'(0));
                    end else begin
                        e = wr_exp.pop_front();
                        check("write_row", 512'(buf_matrix_row), 512'(e.row));
                        pend.push_back('{cyc + WrDelay, e.row, e.data});
                        if (e.row == 8'd0) p0 = cyc;
                        if (e.row == 8'd7) p7 = cyc;
                    end
                end
                if (buf_zigzag_enable) begin
                    // Capture at the first window cycle: all writes must have landed by then.
                    if (en_cnt == 0) begin
                        for (int k = 0; k < 64; k++) zz_model[8*k +: 8] = mem[zr[k]][8*zc[k] +: 8];
                    end
                    en_cnt++;
                end else if (en_cnt != 0) begin
                    check("zz_en_len", 512'(en_cnt), 512'(3));
                    check("valid_after_zz", 512'(zz_out_valid), 512'(1));
                    en_cnt = 0;
                end
                if (zz_out_valid && zz_out_ready) begin
                    hs_cnt++;
                    if (blk_q.size() == 0) begin
                        check("unexpected_block", 512'(1), 512'(0));
                    end else begin
                        bk = blk_q.pop_front();
                        check("zz_result", zz_model, bk.zz);
                        cnt_exp = bk.cnt;
                        cnt_chk = 1;
                    end
                end
            end
        end
    end

    task automatic send_row(input logic [63:0] d, input int r);
        int n = 0;
        in_valid    = 1'b1;
        in_row_data = d;
        while (!in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check("accept_timeout", 512'(1), 512'(0));
        else wr_exp.push_back('{8'(r), d});
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int b, input int gmax, input int first);
        exp_blocks = exp_blocks + 16'd1;
        blk_q.push_back('{golden(b), exp_blocks});
        for (int r = first; r < 8; r++) begin
            send_row(row_data(b, r), r);
            if (gmax > 0) repeat ($urandom_range(gmax, 0)) @(negedge clock);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (blk_q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check("block_timeout", 512'(1), 512'(0));
        @(negedge clock);
    endtask

    task automatic check_rst_outputs(input string name);
        check(name, 512'({in_ready, buf_input_enable, buf_input_data_enable, buf_matrix_row,
                          buf_row_data, buf_zigzag_enable, zz_out_valid, busy, block_count}),
              512'(0));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_rst_outputs("reset_outputs");
        wr_exp.delete();
        blk_q.delete();
        exp_blocks = 16'd0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k = 0;
        int n = 0;
        int hs0;
        for (int s = 0; s < 15; s++) begin
            for (int t = 0; t < 8; t++) begin
                int i;
                i = (s % 2 == 1) ? t : 7 - t;
                if (s - i >= 0 && s - i < 8) begin
                    zr[k] = i;
                    zc[k] = s - i;
                    k++;
                end
            end
        end
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_row_data  = '0;
        zz_out_ready = 1'b1;
        exp_blocks   = 16'd0;
        #1;
        check_rst_outputs("initial_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Back-to-back rows.
        send_block(0, 0, 0);
        wait_done();
        check("pulse_span", 512'(p7 - p0), 512'(7));
        check("busy_idle", 512'(busy), 512'(0));

        // Gapped rows give the same block.
        send_block(0, 5, 0);
        wait_done();

        // Downstream stall with a row offered meanwhile.
        do_reset();
        zz_out_ready = 1'b0;
        send_block(0, 0, 0);
        while (!zz_out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("stall_valid_seen", 512'(zz_out_valid), 512'(1));
        in_valid    = 1'b1;
        in_row_data = row_data(1, 0);
        repeat (20) begin
            @(negedge clock);
            check("stall_valid", 512'(zz_out_valid), 512'(1));
            check("stall_in_ready", 512'(in_ready), 512'(0));
        end
        zz_out_ready = 1'b1;
        send_row(row_data(1, 0), 0);
        send_block(1, 0, 1);
        wait_done();

        // Reset after row 4 of a block.
        do_reset();
        for (int r = 0; r < 5; r++) send_row(row_data(2, r), r);
        do_reset();
        repeat (6) begin
            @(negedge clock);
            check("no_write_after_reset", 512'(buf_input_data_enable), 512'(0));
        end
        check("busy_after_reset", 512'(busy), 512'(0));
        send_block(3, 0, 0);
        wait_done();

        // Three blocks with ready tied high.
        do_reset();
        hs0 = hs_cnt;
        for (int b = 4; b < 7; b++) send_block(b, 0, 0);
        wait_done();
        check("three_pulses", 512'(hs_cnt - hs0), 512'(3));
        check("count_three", 512'(block_count), 512'(3));
        check("busy_after_three", 512'(busy), 512'(0));

        // block_count wrap.
        force dut.block_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.block_count_q;
        @(negedge clock);
        check("count_preload", 512'(block_count), 512'(16'hFFFF));
        exp_blocks = 16'hFFFF;
        send_block(5, 0, 0);
        wait_done();
        check("count_wrap", 512'(block_count), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
